// File: rtl/audio_pkg.sv
// Shared audio definitions: frame geometry, sample type and rate-accumulator increment.
package audio_pkg;

    localparam int FRAME_BITS = 64;
    localparam int SLOT_BITS  = 32;

    typedef logic signed [15:0] sample_t;
    typedef logic [$clog2(FRAME_BITS)-1:0] bitcnt_t;
    typedef logic [$clog2(SLOT_BITS)-1:0]  slot_pos_t;

    // One BCLK half-period per accumulator overflow: 2 edges * 64 bits = 128 per sample.
    function automatic logic [31:0] calc_inc(input logic [31:0] rate);
        return rate * 32'd128;
    endfunction

endpackage

// File: rtl/i2s_clk_gen.sv
// Fractional-accumulator BCLK generator with one-clk fall/rise event strobes.
module i2s_clk_gen
    import audio_pkg::*;
#(
    parameter int unsigned CLK_RATE  = 50_000_000,
    parameter int unsigned BASE_RATE = 48_000
) (
    input  logic clk,
    input  logic reset,
    input  logic sample_rate,
    output logic i2s_bclk,
    output logic bclk_fall,
    output logic bclk_rise
);

    localparam logic [31:0] INC_1X = calc_inc(BASE_RATE);
    localparam logic [31:0] INC_2X = INC_1X << 1;
    localparam logic [32:0] LIMIT  = {1'b0, CLK_RATE};

    logic [31:0] acc;
    logic [31:0] inc;
    logic [32:0] sum;
    logic        tick;

    always_comb begin
        inc  = sample_rate ? INC_2X : INC_1X;
        sum  = {1'b0, acc} + {1'b0, inc};
        tick = (sum >= LIMIT);
    end

    // NOTE: strobes are gated by reset so a tick in a reset cycle never reaches any consumer.
    assign bclk_fall = tick &&  i2s_bclk && !reset;
    assign bclk_rise = tick && !i2s_bclk && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            acc      <= '0;
            i2s_bclk <= 1'b0;
        end else if (tick) begin
            acc      <= 32'(sum - LIMIT);
            i2s_bclk <= ~i2s_bclk;
        end else begin
            acc      <= sum[31:0];
        end
    end

endmodule

// File: rtl/i2s_serializer.sv
// I2S transmitter for the WM8731: 64-BCLK frame, stereo pair latched at frame start.
// Define I2S_LEFT_JUSTIFIED_EN for left-justified output (MSB at bit 0, no one-BCLK delay).
module i2s_serializer
    import audio_pkg::*;
#(
    parameter int unsigned CLK_RATE  = 50_000_000,
    parameter int unsigned BASE_RATE = 48_000,
    parameter int          DATA_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sample_rate,
    input  logic              mute,
    input  logic [DATA_W-1:0] left_in,
    input  logic [DATA_W-1:0] right_in,
    output logic              i2s_bclk,
    output logic              i2s_lrclk,
    output logic              i2s_data,
    output logic              sample_stb
);

    localparam int PW = $clog2(SLOT_BITS);
    localparam logic [PW:0] DW = (PW + 1)'(DATA_W);

    logic              bclk_fall;
    logic              bclk_rise_unused;
    bitcnt_t           bitcnt;
    bitcnt_t           bit_nxt;
    slot_pos_t         pos;
    logic              frame_start;
    logic              data_nxt;
    logic [DATA_W-1:0] l_sh, r_sh;
    logic [DATA_W-1:0] l_load, r_load;
    logic [DATA_W-1:0] slot_word, shifted;

    i2s_clk_gen #(
        .CLK_RATE (CLK_RATE),
        .BASE_RATE(BASE_RATE)
    ) u_clk_gen (
        .clk        (clk),
        .reset      (reset),
        .sample_rate(sample_rate),
        .i2s_bclk   (i2s_bclk),
        .bclk_fall  (bclk_fall),
        .bclk_rise  (bclk_rise_unused)
    );

    assign bit_nxt     = bitcnt + bitcnt_t'(1);
    assign pos         = bit_nxt[PW-1:0];
    assign frame_start = bclk_fall && (bit_nxt == '0);
    assign l_load      = mute ? '0 : left_in;
    assign r_load      = mute ? '0 : right_in;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        data_nxt  = 1'b0;
        slot_word = bit_nxt[PW] ? r_sh : l_sh;
`ifdef I2S_LEFT_JUSTIFIED_EN
        shifted = slot_word << pos;
        if (bit_nxt == '0)
            data_nxt = l_load[DATA_W-1];
        else if ({1'b0, pos} < DW)
            data_nxt = shifted[DATA_W-1];
`else
        shifted = slot_word << (pos - slot_pos_t'(1));
        if (pos != '0 && {1'b0, pos} <= DW)
            data_nxt = shifted[DATA_W-1];
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bitcnt     <= bitcnt_t'(FRAME_BITS - 1);
            l_sh       <= '0;
            r_sh       <= '0;
            i2s_lrclk  <= 1'b1;
            i2s_data   <= 1'b0;
            sample_stb <= 1'b0;
        end else begin
            sample_stb <= frame_start;
            if (bclk_fall) begin
                bitcnt    <= bit_nxt;
                i2s_lrclk <= bit_nxt[PW];
                i2s_data  <= data_nxt;
            end
            if (frame_start) begin
                l_sh <= l_load;
                r_sh <= r_load;
            end
        end
    end

endmodule

// File: tb/tb_i2s_serializer.sv
// Directed bench for i2s_serializer: reset, bit map, mute, mid-frame changes, reset mid-frame, rates.
module tb_i2s_serializer;
    import audio_pkg::*;

    logic    clk = 1'b0;
    logic    reset = 1'b1;
    logic    sample_rate = 1'b0;
    logic    mute = 1'b0;
    sample_t left_in = 16'h0000;
    sample_t right_in = 16'h0000;
    logic    i2s_bclk, i2s_lrclk, i2s_data, sample_stb;

    int checks = 0;
    int errors = 0;
    int stb_cnt = 0;
    int stb_base, lr_cnt, run, min_run, max_run;
    logic have_run, prev_lr, prev_bclk;
    logic [63:0] frame_bits, frame_lr;

    localparam logic [63:0] LR_PATTERN = {32'h0000_0000, 32'hFFFF_FFFF};

    i2s_serializer #(
        .CLK_RATE (50_000_000),
        .BASE_RATE(48_000),
        .DATA_W   (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .sample_rate(sample_rate),
        .mute       (mute),
        .left_in    (left_in),
        .right_in   (right_in),
        .i2s_bclk   (i2s_bclk),
        .i2s_lrclk  (i2s_lrclk),
        .i2s_data   (i2s_data),
        .sample_stb (sample_stb)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (sample_stb) stb_cnt++;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Bit n of the frame sits at position 63-n (first bit shifted in ends up at the MSB).
    function automatic logic [63:0] exp_frame(input logic [15:0] l, input logic [15:0] r);
`ifdef I2S_LEFT_JUSTIFIED_EN
        return {l, 16'h0000, r, 16'h0000};
`else
        return {1'b0, l, 15'h0000, 1'b0, r, 15'h0000};
`endif
    endfunction

    task automatic wait_bclk(input logic level);
        logic ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (i2s_bclk === level) ok = 1'b1;
        end
        if (!ok) chk("bclk_timeout", {63'd0, ok}, 64'd1);
    endtask

    task automatic wait_stb(input int bound, input string tag);
        logic ok = 1'b0;
        for (int i = 0; i < bound && !ok; i++) begin
            @(negedge clk);
            if (sample_stb === 1'b1) ok = 1'b1;
        end
        chk(tag, {63'd0, ok}, 64'd1);
    endtask

    // Starts in the low phase of bit 0, ends at the next frame start.
    task automatic capture_frame(input int act_bit, input int act,
                                 output logic [63:0] d, output logic [63:0] lr);
        d  = '0;
        lr = '0;
        for (int n = 0; n < 64; n++) begin
            wait_bclk(1'b1);
            d  = {d[62:0], i2s_data};
            lr = {lr[62:0], i2s_lrclk};
            if (n == act_bit) begin
                case (act)
                    1:       mute = 1'b1;
                    2:       left_in = 16'h8000;
                    default: ;
                endcase
            end
            wait_bclk(1'b0);
        end
    endtask

    task automatic measure(input int clks);
        lr_cnt   = 0;
        min_run  = 1000;
        max_run  = 0;
        run      = 0;
        have_run = 1'b0;
        prev_lr  = i2s_lrclk;
        prev_bclk = i2s_bclk;
        for (int i = 0; i < clks; i++) begin
            @(negedge clk);
            if (i2s_lrclk && !prev_lr) lr_cnt++;
            prev_lr = i2s_lrclk;
            if (i2s_bclk !== prev_bclk) begin
                if (have_run) begin
                    if (run < min_run) min_run = run;
                    if (run > max_run) max_run = run;
                end
                have_run  = 1'b1;
                run       = 1;
                prev_bclk = i2s_bclk;
            end else begin
                run++;
            end
        end
    endtask

    initial begin
        // 1. Reset held 5 clks.
        left_in  = 16'hA55A;
        right_in = 16'h0F0F;
        repeat (5) @(negedge clk);
        chk("rst_bclk",  {63'd0, i2s_bclk},   64'd0);
        chk("rst_lrclk", {63'd0, i2s_lrclk},  64'd1);
        chk("rst_data",  {63'd0, i2s_data},   64'd0);
        chk("rst_stb",   {63'd0, sample_stb}, 64'd0);
        reset = 1'b0;
        wait_stb(40, "first_stb");
        chk("first_lrclk", {63'd0, i2s_lrclk}, 64'd0);
        @(negedge clk);
        chk("stb_one_clk", {63'd0, sample_stb}, 64'd0);

        // 2. Bit map; left changes after the latch must not affect this frame.
        capture_frame(-1, 0, frame_bits, frame_lr);
        chk("map_a55a_0f0f", frame_bits, exp_frame(16'hA55A, 16'h0F0F));
        chk("lrclk_pattern", frame_lr, LR_PATTERN);
        chk("frame_len", {63'd0, sample_stb}, 64'd1);
        left_in = 16'h7FFF;
        capture_frame(-1, 0, frame_bits, frame_lr);
        chk("latched_a55a", frame_bits, exp_frame(16'hA55A, 16'h0F0F));

        // 4. Mute asserted mid-frame.
        stb_base = stb_cnt;
        capture_frame(20, 1, frame_bits, frame_lr);
        chk("pre_mute_7fff", frame_bits, exp_frame(16'h7FFF, 16'h0F0F));
        chk("stb_per_frame", 64'(stb_cnt - stb_base), 64'd1);
        mute = 1'b0;
        stb_base = stb_cnt;
        capture_frame(-1, 0, frame_bits, frame_lr);
        chk("muted_zero", frame_bits, 64'd0);
        chk("stb_muted", 64'(stb_cnt - stb_base), 64'd1);

        // 5. left_in 7FFF -> 8000 at bitcnt 10.
        capture_frame(10, 2, frame_bits, frame_lr);
        chk("change_7fff", frame_bits, exp_frame(16'h7FFF, 16'h0F0F));
        capture_frame(-1, 0, frame_bits, frame_lr);
        chk("next_8000", frame_bits, exp_frame(16'h8000, 16'h0F0F));

        // 6. Reset pulsed at bitcnt 40.
        left_in  = 16'h1234;
        right_in = 16'h5678;
        repeat (40) begin
            wait_bclk(1'b1);
            wait_bclk(1'b0);
        end
        wait_bclk(1'b1);
        chk("pre_rst_lrclk", {63'd0, i2s_lrclk}, 64'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_bclk",  {63'd0, i2s_bclk},   64'd0);
        chk("midrst_data",  {63'd0, i2s_data},   64'd0);
        chk("midrst_lrclk", {63'd0, i2s_lrclk},  64'd1);
        chk("midrst_stb",   {63'd0, sample_stb}, 64'd0);
        reset = 1'b0;
        wait_stb(40, "restart_stb");
`ifdef I2S_LEFT_JUSTIFIED_EN
        chk("restart_msb", {63'd0, i2s_data}, 64'd0);
`endif
        capture_frame(-1, 0, frame_bits, frame_lr);
        chk("restart_frame", frame_bits, exp_frame(16'h1234, 16'h5678));

        // 3. Rates over 0.5 ms each: 24 +/- 1 frames at 48 kHz, 48 +/- 1 at 96 kHz.
        sample_rate = 1'b0;
        measure(25_000);
        chk("lrck_48k", {63'd0, (lr_cnt >= 23 && lr_cnt <= 25)}, 64'd1);
        chk("bclk_half_min", {63'd0, (min_run >= 8)}, 64'd1);
        chk("bclk_half_max", {63'd0, (max_run <= 9)}, 64'd1);
        sample_rate = 1'b1;
        measure(25_000);
        chk("lrck_96k", {63'd0, (lr_cnt >= 47 && lr_cnt <= 49)}, 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
